// File: rtl/pen_pkg.sv
// pen_pkg: types and constants shared by the light-pen locator.
//   GRID_W / GRID_H : LED matrix dimensions in pixels
//   coord_t         : row or column index into the matrix
//   pen_state_t     : locator FSM states (encoding is visible on the debug LEDs)
//   coord_eq        : compares two (row, col) pairs
package pen_pkg;

    localparam int GRID_W  = 8;
    localparam int GRID_H  = 8;
    localparam int COORD_W = $clog2((GRID_W > GRID_H) ? GRID_W : GRID_H);

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CAND = 2'd1,
        DOWN = 2'd2
    } pen_state_t;

    function automatic logic coord_eq(input coord_t a_row, input coord_t a_col,
                                      input coord_t b_row, input coord_t b_col);
        return (a_row == b_row) && (a_col == b_col);
    endfunction

endpackage

// File: rtl/pen_sync.sv
// pen_sync: two-flop synchronizer for a single asynchronous input.
//   clk_i   : destination clock
//   rst_i   : synchronous reset, active-high; both flops load RST_VAL
//   d_i     : asynchronous input
//   q_o     : synchronized output, two clk_i cycles behind d_i
module pen_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two-stage shift register that resolves metastability on d_i.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pen_locator.sv
// pen_locator: turns the raw light-pen input into confirmed 8x8 pixel hits.
//   clk, rst          : clock and synchronous active-high reset
//   pen_n             : raw phototransistor pin, active-low, asynchronous
//   slot_valid        : pulse on the last cycle of each lit pixel slot
//   scan_row/scan_col : coordinate of that slot
//   frame_end         : pulse after the last slot of a frame
//   hit_valid         : one-cycle pulse announcing a new confirmed coordinate
//   hit_row/hit_col   : last confirmed coordinate, held between pulses
//   pen_down          : level, pen resting on a lit pixel
//   state_o           : FSM state (IDLE=0, CAND=1, DOWN=2)
module pen_locator
    import pen_pkg::*;
#(
    parameter int CONFIRM_FRAMES = 2,
    parameter int LIFT_FRAMES    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pen_n,
    input  logic       slot_valid,
    input  logic [2:0] scan_row,
    input  logic [2:0] scan_col,
    input  logic       frame_end,
    output logic       hit_valid,
    output logic [2:0] hit_row,
    output logic [2:0] hit_col,
    output logic       pen_down,
    output logic [1:0] state_o
);

    localparam int CW = $clog2(CONFIRM_FRAMES + 1);
    localparam int MW = $clog2(LIFT_FRAMES + 1);
    localparam logic [CW-1:0] CONF_MAX = CW'(CONFIRM_FRAMES);
    localparam logic [MW-1:0] MISS_MAX = MW'(LIFT_FRAMES);
    localparam logic [CW-1:0] CONF_ONE = CW'(1);
    localparam logic [MW-1:0] MISS_ONE = MW'(1);

    logic       pen_sync_s;
    logic       pen_s;
    logic       slot_hit_s;
    logic       eval_s;
    logic       eval_hit_s;
    coord_t     eval_row_s;
    coord_t     eval_col_s;
    logic       cand_match_s;
    logic       same_as_last_s;
    logic       confirm_s;
    logic       lift_s;
    logic [CW-1:0] conf_next_s;
    logic [MW-1:0] miss_next_s;

    pen_state_t state_q, state_d;
    logic       frame_hit_q, frame_hit_d;
    coord_t     frame_row_q, frame_row_d;
    coord_t     frame_col_q, frame_col_d;
    logic       armed_q, armed_d;
    coord_t     cand_row_q, cand_row_d;
    coord_t     cand_col_q, cand_col_d;
    logic [CW-1:0] conf_cnt_q, conf_cnt_d;
    logic [MW-1:0] miss_cnt_q, miss_cnt_d;
    logic       hit_valid_q, hit_valid_d;
    coord_t     hit_row_q, hit_row_d;
    coord_t     hit_col_q, hit_col_d;
    logic       pen_down_q, pen_down_d;

    // Synchronizer idles high so reset looks like "pen not seeing light".
    pen_sync #(.RST_VAL(1'b1)) u_sync (
        .clk_i (clk),
        .rst_i (rst),
        .d_i   (pen_n),
        .q_o   (pen_sync_s)
    );

    assign pen_s      = ~pen_sync_s;
    assign slot_hit_s = slot_valid & pen_s;

    // A slot coinciding with frame_end still belongs to the frame being judged,
    // so it is merged in here instead of going through the capture registers.
    assign eval_s     = frame_end & armed_q;
    assign eval_hit_s = frame_hit_q | slot_hit_s;
    assign eval_row_s = frame_hit_q ? frame_row_q : scan_row;
    assign eval_col_s = frame_hit_q ? frame_col_q : scan_col;

    // A zero count means no candidate is held, so coordinates alone do not match.
    assign cand_match_s   = (conf_cnt_q != {CW{1'b0}}) &&
                            coord_eq(eval_row_s, eval_col_s, cand_row_q, cand_col_q);
    assign same_as_last_s = coord_eq(eval_row_s, eval_col_s, hit_row_q, hit_col_q);
    assign conf_next_s    = !cand_match_s ? CONF_ONE :
                            (conf_cnt_q >= CONF_MAX) ? CONF_MAX : conf_cnt_q + CONF_ONE;
    assign miss_next_s    = (miss_cnt_q >= MISS_MAX) ? MISS_MAX : miss_cnt_q + MISS_ONE;
    assign confirm_s      = (conf_next_s >= CONF_MAX);
    assign lift_s         = (miss_next_s >= MISS_MAX);

    // Frame capture: first pen sample in scan order wins; frame_end rearms it.
    always_comb begin
        frame_hit_d = frame_hit_q;
        frame_row_d = frame_row_q;
        frame_col_d = frame_col_q;
        armed_d     = armed_q;
        if (frame_end) begin
            frame_hit_d = 1'b0;
            armed_d     = 1'b1;
        end else if (slot_hit_s && !frame_hit_q) begin
            frame_hit_d = 1'b1;
            frame_row_d = scan_row;
            frame_col_d = scan_col;
        end else begin
            frame_hit_d = frame_hit_q;
        end
    end

    // Next-state logic, stepped once per armed frame_end.
    always_comb begin
        state_d = state_q;
        if (eval_s) begin
            case (state_q)
                IDLE, CAND: begin
                    if (eval_hit_s) begin
                        state_d = confirm_s ? DOWN : CAND;
                    end else begin
                        state_d = IDLE;
                    end
                end
                DOWN: begin
                    if (!eval_hit_s && lift_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DOWN;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Datapath and output next values: candidate tracking, counters, report.
    always_comb begin
        cand_row_d  = cand_row_q;
        cand_col_d  = cand_col_q;
        conf_cnt_d  = conf_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        hit_valid_d = 1'b0;
        hit_row_d   = hit_row_q;
        hit_col_d   = hit_col_q;
        pen_down_d  = pen_down_q;
        if (eval_s) begin
            case (state_q)
                IDLE, CAND: begin
                    if (eval_hit_s && confirm_s) begin
                        cand_row_d  = eval_row_s;
                        cand_col_d  = eval_col_s;
                        conf_cnt_d  = {CW{1'b0}};
                        miss_cnt_d  = {MW{1'b0}};
                        hit_valid_d = 1'b1;
                        hit_row_d   = eval_row_s;
                        hit_col_d   = eval_col_s;
                        pen_down_d  = 1'b1;
                    end else if (eval_hit_s) begin
                        cand_row_d = eval_row_s;
                        cand_col_d = eval_col_s;
                        conf_cnt_d = conf_next_s;
                    end else begin
                        conf_cnt_d = {CW{1'b0}};
                        miss_cnt_d = {MW{1'b0}};
                    end
                end
                DOWN: begin
                    if (eval_hit_s && same_as_last_s) begin
                        // Pen still on the reported pixel: refresh, never re-announce.
                        miss_cnt_d = {MW{1'b0}};
                        conf_cnt_d = {CW{1'b0}};
                    end else if (eval_hit_s && confirm_s) begin
                        cand_row_d  = eval_row_s;
                        cand_col_d  = eval_col_s;
                        conf_cnt_d  = {CW{1'b0}};
                        miss_cnt_d  = {MW{1'b0}};
                        hit_valid_d = 1'b1;
                        hit_row_d   = eval_row_s;
                        hit_col_d   = eval_col_s;
                        pen_down_d  = 1'b1;
                    end else if (eval_hit_s) begin
                        cand_row_d = eval_row_s;
                        cand_col_d = eval_col_s;
                        conf_cnt_d = conf_next_s;
                        miss_cnt_d = {MW{1'b0}};
                    end else if (lift_s) begin
                        pen_down_d = 1'b0;
                        conf_cnt_d = {CW{1'b0}};
                        miss_cnt_d = {MW{1'b0}};
                    end else begin
                        miss_cnt_d = miss_next_s;
                    end
                end
                default: begin
                    conf_cnt_d = {CW{1'b0}};
                    miss_cnt_d = {MW{1'b0}};
                    pen_down_d = 1'b0;
                end
            endcase
        end else begin
            hit_valid_d = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame capture, datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_hit_q <= 1'b0;
            frame_row_q <= 3'd0;
            frame_col_q <= 3'd0;
            armed_q     <= 1'b0;
            cand_row_q  <= 3'd0;
            cand_col_q  <= 3'd0;
            conf_cnt_q  <= {CW{1'b0}};
            miss_cnt_q  <= {MW{1'b0}};
            hit_valid_q <= 1'b0;
            hit_row_q   <= 3'd0;
            hit_col_q   <= 3'd0;
            pen_down_q  <= 1'b0;
        end else begin
            frame_hit_q <= frame_hit_d;
            frame_row_q <= frame_row_d;
            frame_col_q <= frame_col_d;
            armed_q     <= armed_d;
            cand_row_q  <= cand_row_d;
            cand_col_q  <= cand_col_d;
            conf_cnt_q  <= conf_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            hit_valid_q <= hit_valid_d;
            hit_row_q   <= hit_row_d;
            hit_col_q   <= hit_col_d;
            pen_down_q  <= pen_down_d;
        end
    end

    assign hit_valid = hit_valid_q;
    assign hit_row   = hit_row_q;
    assign hit_col   = hit_col_q;
    assign pen_down  = pen_down_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_pen_locator.sv
// Directed self-checking bench for pen_locator: each frame scans all 64
// slots (4 cycles per slot, slot_valid on the last), with the pen placed
// on up to two pixels, then compares the outputs one cycle after frame_end.
module tb_pen_locator;

    logic       clk = 1'b0;
    logic       rst;
    logic       pen_n;
    logic       slot_valid;
    logic [2:0] scan_row;
    logic [2:0] scan_col;
    logic       frame_end;
    logic       hit_valid;
    logic [2:0] hit_row;
    logic [2:0] hit_col;
    logic       pen_down;
    logic [1:0] state_o;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    pen_locator #(.CONFIRM_FRAMES(2), .LIFT_FRAMES(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .pen_n      (pen_n),
        .slot_valid (slot_valid),
        .scan_row   (scan_row),
        .scan_col   (scan_col),
        .frame_end  (frame_end),
        .hit_valid  (hit_valid),
        .hit_row    (hit_row),
        .hit_col    (hit_col),
        .pen_down   (pen_down),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    // Counts every hit_valid cycle so stray pulses between checkpoints show up.
    always @(negedge clk) begin
        if (hit_valid === 1'b1) pulses++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input int hv, input int r, input int c,
                                 input int pd, input int st);
        check({tag, ".hit_valid"}, 32'(hit_valid), 32'(hv));
        check({tag, ".hit_row"},   32'(hit_row),   32'(r));
        check({tag, ".hit_col"},   32'(hit_col),   32'(c));
        check({tag, ".pen_down"},  32'(pen_down),  32'(pd));
        check({tag, ".state"},     32'(state_o),   32'(st));
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst        = 1'b1;
        pen_n      = 1'b1;
        slot_valid = 1'b0;
        frame_end  = 1'b0;
        scan_row   = 3'd0;
        scan_col   = 3'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_outputs(tag, 0, 0, 0, 0, 0);
    endtask

    // One full frame; on1/on2 place the pen on (r1,c1)/(r2,c2). With coinc set,
    // frame_end is raised together with the slot_valid of slot (7,7).
    task automatic run_frame(input string tag,
                             input bit on1, input int r1, input int c1,
                             input bit on2, input int r2, input int c2,
                             input bit coinc,
                             input int exp_hv, input int exp_r, input int exp_c,
                             input int exp_pd, input int exp_st);
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                @(negedge clk);
                slot_valid = 1'b0;
                scan_row   = 3'(r);
                scan_col   = 3'(c);
                pen_n      = !((on1 && r == r1 && c == c1) || (on2 && r == r2 && c == c2));
                repeat (3) @(negedge clk);
                slot_valid = 1'b1;
                if (coinc && r == 7 && c == 7) frame_end = 1'b1;
            end
        end
        @(negedge clk);
        slot_valid = 1'b0;
        pen_n      = 1'b1;
        if (!coinc) begin
            frame_end = 1'b1;
            @(negedge clk);
        end
        frame_end = 1'b0;
        check_outputs(tag, exp_hv, exp_r, exp_c, exp_pd, exp_st);
        @(negedge clk);
        check({tag, ".pulse_end"}, 32'(hit_valid), 32'd0);
    endtask

    initial begin
        rst = 1'b1; pen_n = 1'b1; slot_valid = 1'b0; frame_end = 1'b0;
        scan_row = 3'd0; scan_col = 3'd0;

        // Idle pen: five frames, nothing reported.
        do_reset("rst_a");
        for (int f = 0; f < 5; f++) begin
            run_frame($sformatf("idle%0d", f), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        end

        // Pen on (3,5) in frames 2 and 3 after reset; frame 1 is discarded.
        do_reset("rst_b");
        run_frame("b_f1", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        run_frame("b_f2", 1, 3, 5, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        run_frame("b_f3", 1, 3, 5, 0, 0, 0, 0, 1, 3, 5, 1, 2);

        // Pen stays on (3,5): deduplicated, then lifts after 3 empty frames.
        for (int f = 0; f < 4; f++) begin
            run_frame($sformatf("hold%0d", f), 1, 3, 5, 0, 0, 0, 0, 0, 3, 5, 1, 2);
        end
        run_frame("miss1", 0, 0, 0, 0, 0, 0, 0, 0, 3, 5, 1, 2);
        run_frame("miss2", 0, 0, 0, 0, 0, 0, 0, 0, 3, 5, 1, 2);
        run_frame("miss3", 0, 0, 0, 0, 0, 0, 0, 0, 3, 5, 0, 0);

        // Candidate (3,5) replaced by (4,5), which is then confirmed.
        run_frame("d_35",  1, 3, 5, 0, 0, 0, 0, 0, 3, 5, 0, 1);
        run_frame("d_45a", 1, 4, 5, 0, 0, 0, 0, 0, 3, 5, 0, 1);
        run_frame("d_45b", 1, 4, 5, 0, 0, 0, 0, 1, 4, 5, 1, 2);
        run_frame("d_m1",  0, 0, 0, 0, 0, 0, 0, 0, 4, 5, 1, 2);
        run_frame("d_m2",  0, 0, 0, 0, 0, 0, 0, 0, 4, 5, 1, 2);
        run_frame("d_m3",  0, 0, 0, 0, 0, 0, 0, 0, 4, 5, 0, 0);

        // Two spots per frame: (1,1) precedes (6,6) in scan order.
        run_frame("e_two1", 1, 1, 1, 1, 6, 6, 0, 0, 4, 5, 0, 1);
        run_frame("e_two2", 1, 1, 1, 1, 6, 6, 0, 1, 1, 1, 1, 2);
        // Slot (7,7) coincident with frame_end; confirmed while already down.
        run_frame("e_c77a", 1, 7, 7, 0, 0, 0, 1, 0, 1, 1, 1, 2);
        run_frame("e_c77b", 1, 7, 7, 0, 0, 0, 1, 1, 7, 7, 1, 2);

        // Reset after one confirming frame discards the candidate.
        do_reset("rst_f");
        run_frame("f_pre1", 1, 2, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        run_frame("f_pre2", 1, 2, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        do_reset("rst_f2");
        run_frame("f_post1", 1, 2, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        run_frame("f_post2", 1, 2, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        run_frame("f_post3", 1, 2, 2, 0, 0, 0, 0, 1, 2, 2, 1, 2);

        check("total_pulses", 32'(pulses), 32'd5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
